// File: rtl/dsp_seq.sv
// Microcode sequencer feeding the DSP address generator: fetches program words
// from a 1-cycle-latency ROM and replays the program once per state vector.
module dsp_seq #(
   parameter int PROG_AW      = 4,
   parameter int OFFSET_WIDTH = 4,
   parameter int STATE_COUNT  = 4,
   parameter int INSTR_W      = OFFSET_WIDTH + 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    abort,
   output logic [PROG_AW-1:0]      instr_addr,
   input  logic [INSTR_W-1:0]      instr_data,
   output logic [3:0]              addr_sel,
   output logic [OFFSET_WIDTH-1:0] addr_ptr,
   output logic                    series_inc,
   output logic                    series_rst,
   output logic                    issue_valid,
   output logic [7:0]              pass_idx,
   output logic                    busy,
   output logic                    done,
   output logic                    overrun
);

   typedef enum logic [2:0] {IDLE, FETCH, RUN, WRAP, DONE} state_t;

   localparam logic [PROG_AW-1:0] ADDR_MAX  = '1;
   localparam logic [7:0]         LAST_PASS = 8'(STATE_COUNT - 1);

   localparam int BIT_LAST = OFFSET_WIDTH;
   localparam int BIT_ADV  = OFFSET_WIDTH + 1;
   localparam int BIT_SINC = OFFSET_WIDTH + 2;

   state_t                  state_reg, state_next;
   logic [PROG_AW-1:0]      instr_addr_reg, instr_addr_next;
   logic [3:0]              addr_sel_reg, addr_sel_next;
   logic [OFFSET_WIDTH-1:0] addr_ptr_reg, addr_ptr_next;
   logic                    series_inc_reg, series_inc_next;
   logic                    series_rst_reg, series_rst_next;
   logic                    issue_valid_reg, issue_valid_next;
   logic [7:0]              pass_idx_reg, pass_idx_next;
   logic                    busy_reg, busy_next;
   logic                    done_reg, done_next;
   logic                    overrun_reg, overrun_next;
   // Set when the word now on instr_data came from the top ROM address.
   logic                    at_end_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         instr_addr_reg  <= '0;
         addr_sel_reg    <= '0;
         addr_ptr_reg    <= '0;
         series_inc_reg  <= 1'b0;
         series_rst_reg  <= 1'b0;
         issue_valid_reg <= 1'b0;
         pass_idx_reg    <= '0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
         overrun_reg     <= 1'b0;
         at_end_reg      <= 1'b0;
      end else begin
         state_reg       <= state_next;
         instr_addr_reg  <= instr_addr_next;
         addr_sel_reg    <= addr_sel_next;
         addr_ptr_reg    <= addr_ptr_next;
         series_inc_reg  <= series_inc_next;
         series_rst_reg  <= series_rst_next;
         issue_valid_reg <= issue_valid_next;
         pass_idx_reg    <= pass_idx_next;
         busy_reg        <= busy_next;
         done_reg        <= done_next;
         overrun_reg     <= overrun_next;
         at_end_reg      <= (instr_addr_reg == ADDR_MAX);
      end
   end

   always_comb begin
      state_next = state_reg;
      if (state_reg != IDLE && abort) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE:  if (start && !abort) state_next = FETCH;
            FETCH: state_next = RUN;
            RUN:   if (instr_data[BIT_LAST] || at_end_reg) state_next = WRAP;
            WRAP:  state_next = (pass_idx_reg == LAST_PASS) ? DONE : FETCH;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      instr_addr_next  = instr_addr_reg;
      addr_sel_next    = 4'b0000;
      addr_ptr_next    = addr_ptr_reg;
      series_inc_next  = 1'b0;
      series_rst_next  = 1'b0;
      issue_valid_next = 1'b0;
      pass_idx_next    = pass_idx_reg;
      done_next        = 1'b0;
      overrun_next     = overrun_reg;
      busy_next        = (state_next != IDLE);

      if (state_reg != IDLE && abort) begin
         addr_sel_next   = 4'b1010;
         series_rst_next = 1'b1;
         pass_idx_next   = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start && !abort) begin
                  addr_sel_next   = 4'b1010;
                  series_rst_next = 1'b1;
                  pass_idx_next   = '0;
                  overrun_next    = 1'b0;
                  instr_addr_next = '0;
               end
            end
            FETCH: instr_addr_next = instr_addr_reg + 1'b1;
            RUN: begin
               addr_ptr_next    = instr_data[OFFSET_WIDTH-1:0];
               addr_sel_next[2] = instr_data[BIT_ADV];
               series_inc_next  = instr_data[BIT_SINC];
               issue_valid_next = 1'b1;
               if (!instr_data[BIT_LAST]) begin
                  // The top word is still issued; the address holds rather than wraps.
                  if (at_end_reg)
                     overrun_next = 1'b1;
                  else if (instr_addr_reg != ADDR_MAX)
                     instr_addr_next = instr_addr_reg + 1'b1;
               end
            end
            WRAP: begin
               // Completion strobes are registered on entry so they are visible in DONE.
               if (pass_idx_reg == LAST_PASS) begin
                  done_next       = 1'b1;
                  addr_sel_next   = 4'b1010;
                  series_rst_next = 1'b1;
               end else begin
                  pass_idx_next   = pass_idx_reg + 8'd1;
                  addr_sel_next   = 4'b1001;
                  instr_addr_next = '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign instr_addr  = instr_addr_reg;
   assign addr_sel    = addr_sel_reg;
   assign addr_ptr    = addr_ptr_reg;
   assign series_inc  = series_inc_reg;
   assign series_rst  = series_rst_reg;
   assign issue_valid = issue_valid_reg;
   assign pass_idx    = pass_idx_reg;
   assign busy        = busy_reg;
   assign done        = done_reg;
   assign overrun     = overrun_reg;

endmodule
